// File: rtl/mem_arb_pkg.sv
// Shared types and default constants for the CPU/DMA memory-port arbiter.
package mem_arb_pkg;

  typedef enum logic [0:0] {
    ST_ARB   = 1'b0,
    ST_BURST = 1'b1
  } arb_state_e;

  localparam int ADDR_W_DEF    = 14;
  localparam int MAX_WAIT_DEF  = 8;
  localparam int BURST_MAX_DEF = 16;

endpackage

// File: rtl/mem_port_arb_if.sv
// Bundle of CPU, DMA and BRAM signals around the shared memory port.
// Handshake: a request is accepted in any cycle its requester sees the grant
// (CPU: cpu_req & ~cpu_stall, DMA: dma_gnt); an ungranted requester holds its
// request and payload stable until accepted.
interface mem_port_arb_if #(
  parameter int ADDR_W = 14
);
  logic              cpu_req;
  logic [3:0]        cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [31:0]       cpu_din;
  logic              cpu_stall;
  logic              cpu_rvalid;
  logic [31:0]       cpu_dout;

  logic              dma_req;
  logic [3:0]        dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [31:0]       dma_din;
  logic              dma_last;
  logic              dma_gnt;
  logic              dma_rvalid;
  logic [31:0]       dma_dout;

  logic              mem_en;
  logic [3:0]        mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_din;
  logic [31:0]       mem_dout;

  // Requesters and the BRAM live on the master side.
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_din,
    output dma_req, dma_we, dma_addr, dma_din, dma_last,
    output mem_dout,
    input  cpu_stall, cpu_rvalid, cpu_dout,
    input  dma_gnt, dma_rvalid, dma_dout,
    input  mem_en, mem_we, mem_addr, mem_din
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_din,
    input  dma_req, dma_we, dma_addr, dma_din, dma_last,
    input  mem_dout,
    output cpu_stall, cpu_rvalid, cpu_dout,
    output dma_gnt, dma_rvalid, dma_dout,
    output mem_en, mem_we, mem_addr, mem_din
  );

endinterface

// File: rtl/mem_port_arb.sv
// Single-port BRAM arbiter: CPU priority with DMA starvation guard and locked
// DMA bursts; read data returns one cycle after a granted read.
module mem_port_arb
  import mem_arb_pkg::*;
#(
  parameter  int ADDR_W    = ADDR_W_DEF,
  parameter  int MAX_WAIT  = MAX_WAIT_DEF,
  parameter  int BURST_MAX = BURST_MAX_DEF,
  localparam int WAIT_W    = $clog2(MAX_WAIT + 1),
  localparam int BEAT_W    = $clog2(BURST_MAX + 1)
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arb_if.slave     bus,
  output arb_state_e        o_state,
  output logic [WAIT_W-1:0] o_wait_cnt,
  output logic [BEAT_W-1:0] o_beat_cnt
);

  arb_state_e        r_state;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [BEAT_W-1:0] r_beat_cnt;
  logic              r_cpu_rd;
  logic              r_dma_rd;

  arb_state_e        w_state_nxt;
  logic [WAIT_W-1:0] w_wait_nxt;
  logic [BEAT_W-1:0] w_beat_nxt;
  logic              w_cpu_grant;
  logic              w_dma_grant;
  logic              w_force_dma;

  assign w_force_dma = bus.dma_req && (r_wait_cnt == WAIT_W'(MAX_WAIT));

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= ST_ARB;
      r_wait_cnt <= '0;
      r_beat_cnt <= '0;
      r_cpu_rd   <= 1'b0;
      r_dma_rd   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_nxt;
      r_beat_cnt <= w_beat_nxt;
      r_cpu_rd   <= w_cpu_grant && (bus.cpu_we == 4'h0);
      r_dma_rd   <= w_dma_grant && (bus.dma_we == 4'h0);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_beat_nxt  = r_beat_cnt;
    unique case (r_state)
      ST_ARB: begin
        w_beat_nxt = '0;
        if (w_dma_grant && !bus.dma_last && (BURST_MAX > 1)) begin
          w_state_nxt = ST_BURST;
          w_beat_nxt  = BEAT_W'(1);
        end
      end
      ST_BURST: begin
        if (w_dma_grant) begin
          // Beat count reaching BURST_MAX ends the lock even without dma_last.
          if (bus.dma_last || (r_beat_cnt == BEAT_W'(BURST_MAX - 1))) begin
            w_state_nxt = ST_ARB;
            w_beat_nxt  = '0;
          end else begin
            w_beat_nxt = r_beat_cnt + BEAT_W'(1);
          end
        end
      end
      default: begin
        w_state_nxt = ST_ARB;
        w_beat_nxt  = '0;
      end
    endcase

    w_wait_nxt = '0;
    if (bus.dma_req && !w_dma_grant) begin
      w_wait_nxt = (r_wait_cnt == WAIT_W'(MAX_WAIT)) ? r_wait_cnt : r_wait_cnt + WAIT_W'(1);
    end
  end

  always_comb begin
    w_cpu_grant = 1'b0;
    w_dma_grant = 1'b0;
    if (rst) begin
      unique case (r_state)
        ST_ARB: begin
          if (w_force_dma)      w_dma_grant = 1'b1;
          else if (bus.cpu_req) w_cpu_grant = 1'b1;
          else if (bus.dma_req) w_dma_grant = 1'b1;
        end
        ST_BURST: w_dma_grant = bus.dma_req;
        default: begin
          w_cpu_grant = 1'b0;
          w_dma_grant = 1'b0;
        end
      endcase
    end

    bus.mem_en   = w_cpu_grant || w_dma_grant;
    bus.mem_we   = 4'h0;
    bus.mem_addr = '0;
    bus.mem_din  = '0;
    if (w_cpu_grant) begin
      bus.mem_we   = bus.cpu_we;
      bus.mem_addr = bus.cpu_addr;
      bus.mem_din  = bus.cpu_din;
    end else if (w_dma_grant) begin
      bus.mem_we   = bus.dma_we;
      bus.mem_addr = bus.dma_addr;
      bus.mem_din  = bus.dma_din;
    end

    bus.cpu_stall = rst && bus.cpu_req && !w_cpu_grant;
    bus.dma_gnt   = w_dma_grant;

    // Return flags are masked while reset is held, since they clear only at the edge.
    bus.cpu_rvalid = rst && r_cpu_rd;
    bus.dma_rvalid = rst && r_dma_rd;
    bus.cpu_dout   = bus.cpu_rvalid ? bus.mem_dout : 32'h0;
    bus.dma_dout   = bus.dma_rvalid ? bus.mem_dout : 32'h0;
  end

  assign o_state    = r_state;
  assign o_wait_cnt = r_wait_cnt;
  assign o_beat_cnt = r_beat_cnt;

endmodule

// File: doc/mem_port_arb.md
MEM_PORT_ARB -- requirements
Module: mem_port_arb

Interface
REQ-001 SHALL have parameter ADDR_W, default 14: word-address width of the shared memory port.
REQ-002 SHALL have parameter MAX_WAIT, default 8: cycles a blocked DMA request waits before forced service.
REQ-003 SHALL have parameter BURST_MAX, default 16: maximum beats in one locked DMA burst.
REQ-004 SHALL have ports: clk  in  1  sole clock, all state on rising edge.
REQ-005 SHALL have ports: rst  in  1  synchronous, active-low reset (0 = reset).
REQ-006 SHALL have ports: cpu_req in 1, cpu_we in 4, cpu_addr in ADDR_W, cpu_din in 32  -- MEM-stage access; we==0 means read.
REQ-007 SHALL have ports: cpu_stall out 1, cpu_rvalid out 1, cpu_dout out 32  -- stall request to pipeline and read return.
REQ-008 SHALL have ports: dma_req in 1, dma_we in 4, dma_addr in ADDR_W, dma_din in 32, dma_last in 1  -- loader access; dma_last marks final burst beat.
REQ-009 SHALL have ports: dma_gnt out 1, dma_rvalid out 1, dma_dout out 32.
REQ-010 SHALL have ports: mem_en out 1, mem_we out 4, mem_addr out ADDR_W, mem_din out 32, mem_dout in 32  -- single port to synchronous BRAM, 1-cycle read latency.

Function
REQ-011 SHALL grant at most one requester per cycle; the granted requester's we/addr/din drive mem_*, mem_en=1; no grant gives mem_en=0, mem_we=0.
REQ-012 SHALL be combinational from request to grant: cpu_stall = cpu_req & ~cpu_grant; dma_gnt = dma_req & dma_grant, same cycle.
REQ-013 SHALL implement FSM states ARB and BURST.
REQ-014 In ARB: if dma_req and wait_cnt==MAX_WAIT grant DMA; else if cpu_req grant CPU; else if dma_req grant DMA.
REQ-015 In ARB, a DMA grant with dma_last=0 SHALL move to BURST, beat_cnt=1; with dma_last=1 remain ARB.
REQ-016 In BURST: DMA owns the port, CPU never granted; cycles with dma_req=0 issue nothing but stay BURST.
REQ-017 In BURST, a granted beat with dma_last=1, or the BURST_MAX-th granted beat, SHALL return to ARB; truncated bursts resume via normal arbitration.
REQ-018 wait_cnt SHALL increment (saturating at MAX_WAIT) each cycle dma_req & ~dma_gnt, and clear on any DMA grant or dma_req=0.
REQ-019 A granted read (we==0) SHALL assert the owner's rvalid exactly one cycle later, with *_dout = mem_dout that cycle; writes never raise rvalid.
REQ-020 cpu_dout/dma_dout SHALL be 0 when the respective rvalid is 0.
REQ-021 Simultaneous CPU and DMA request with wait_cnt<MAX_WAIT in ARB SHALL grant CPU; DMA is held, not dropped.

Reset
REQ-022 On rst=0 at a clock edge: state=ARB, wait_cnt=0, beat_cnt=0, rvalid registers=0, including mid-burst.
REQ-023 While rst=0, grants SHALL be suppressed: mem_en=0, mem_we=0, dma_gnt=0, cpu_stall=0, rvalid=0.

Structure
REQ-024 FSM state encoding and default parameter constants SHALL live in shared package mem_arb_pkg.
REQ-025 No sub-module required; the 1-cycle read-return tag (owner, is_read) MAY be a small register inside the block.

Verification
REQ-026 CPU read addr 0x010 alone -> same-cycle mem_en=1, mem_addr=0x010, cpu_stall=0; next cycle cpu_rvalid=1, cpu_dout=mem_dout.
REQ-027 CPU and DMA request continuously, DMA single beats -> CPU granted 8 cycles, DMA granted on 9th, cpu_stall=1 that cycle, pattern repeats.
REQ-028 DMA 4-beat write burst (dma_last on beat 4) with cpu_req held -> 4 consecutive DMA grants, cpu_stall=1 throughout, CPU granted next cycle.
REQ-029 DMA burst never asserting dma_last -> exactly 16 grants then ARB; CPU granted on 17th cycle if requesting.
REQ-030 DMA burst with dma_req gap of 3 cycles at beat 2 -> mem_en=0 during gap, CPU still stalled, burst resumes at beat 3.
REQ-031 rst=0 asserted mid-burst beat 5 -> next cycle state ARB, all counters 0, no rvalid; after release CPU request granted immediately.
